// File: rtl/kv10_mem_pkg.sv
// Shared types and sizes for the main-memory arbiter.
// Address/word widths follow the KV10 physical address and word.
package kv10_mem_pkg;

  localparam int PADDR_W     = 18;
  localparam int WORD_W      = 36;
  localparam int ARB_TIMEOUT = 15;
  localparam int WD_W        = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_DMA
  } req_id_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// NXM watchdog: counts WAIT cycles, expires on the
// cycle whose increment would reach TIMEOUT.
module mem_arb_watchdog
  import kv10_mem_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable &&
    (count == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter for single-port main memory,
// one access at a time, with NXM timeout.
module mem_arbiter
  import kv10_mem_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0]  cpu_write_data,
  input  logic               cpu_read,
  input  logic               cpu_write,
  output logic [WORD_W-1:0]  cpu_read_data,
  output logic               cpu_read_ack,
  output logic               cpu_write_ack,
  output logic               cpu_nxm,
  input  logic [PADDR_W-1:0] dma_addr,
  input  logic [WORD_W-1:0]  dma_write_data,
  input  logic               dma_read,
  input  logic               dma_write,
  output logic [WORD_W-1:0]  dma_read_data,
  output logic               dma_read_ack,
  output logic               dma_write_ack,
  output logic               dma_nxm,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [WORD_W-1:0]  mem_read_data,
  input  logic               read_ack,
  input  logic               write_ack
);

  arb_state_t         state, state_d;
  req_id_t            grant, last_grant, win;
  logic [PADDR_W-1:0] addr_r;
  logic [WORD_W-1:0]  wdata_r, rdata_r;
  logic               op_wr, nxm_r;
  logic               cpu_req, dma_req;
  logic               ack, expired, take;
  logic               done, ok_rd, ok_wr, bad;
  logic               cpu_sel, dma_sel;

  assign cpu_req = cpu_read | cpu_write;
  assign dma_req = dma_read | dma_write;
  assign ack     = op_wr ? write_ack : read_ack;

  always_comb begin
    state_d = state;
    win     = REQ_CPU;
    take    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (cpu_req || dma_req) begin
          take    = 1'b1;
          state_d = ARB_ISSUE;
          if (cpu_req && dma_req) begin
            win = (last_grant == REQ_DMA) ?
                  REQ_CPU : REQ_DMA;
          end else if (cpu_req) begin
            win = REQ_CPU;
          end else begin
            win = REQ_DMA;
          end
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (ack || expired) state_d = ARB_DONE;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant      <= REQ_CPU;
      last_grant <= REQ_DMA;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      op_wr      <= 1'b0;
      nxm_r      <= 1'b0;
    end else begin
      state <= state_d;
      if (take) begin
        grant      <= win;
        last_grant <= win;
        nxm_r      <= 1'b0;
        rdata_r    <= '0;
        // write wins over read when both are raised
        if (win == REQ_CPU) begin
          addr_r  <= cpu_addr;
          wdata_r <= cpu_write_data;
          op_wr   <= cpu_write;
        end else begin
          addr_r  <= dma_addr;
          wdata_r <= dma_write_data;
          op_wr   <= dma_write;
        end
      end
      if (state == ARB_WAIT) begin
        if (ack) begin
          if (!op_wr) rdata_r <= mem_read_data;
        end else if (expired) begin
          nxm_r <= 1'b1;
        end
      end
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ARB_ISSUE),
    .enable (state == ARB_WAIT),
    .expired(expired)
  );

  assign done    = (state == ARB_DONE);
  assign ok_rd   = done && !nxm_r && !op_wr;
  assign ok_wr   = done && !nxm_r && op_wr;
  assign bad     = done && nxm_r;
  assign cpu_sel = (grant == REQ_CPU);
  assign dma_sel = (grant == REQ_DMA);

  assign cpu_read_ack  = ok_rd && cpu_sel;
  assign cpu_write_ack = ok_wr && cpu_sel;
  assign cpu_nxm       = bad && cpu_sel;
  assign cpu_read_data = cpu_read_ack ? rdata_r : '0;
  assign dma_read_ack  = ok_rd && dma_sel;
  assign dma_write_ack = ok_wr && dma_sel;
  assign dma_nxm       = bad && dma_sel;
  assign dma_read_data = dma_read_ack ? rdata_r : '0;

  assign mem_read       = (state == ARB_ISSUE) && !op_wr;
  assign mem_write      = (state == ARB_ISSUE) && op_wr;
  assign mem_addr       = addr_r;
  assign mem_write_data = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected
// mem ops and responses, monitors pop and compare.
module tb_mem_arbiter;
  import kv10_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [PADDR_W-1:0] cpu_addr = '0, dma_addr = '0;
  logic [PADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] cpu_write_data = '0, dma_write_data = '0;
  logic [WORD_W-1:0] cpu_read_data, dma_read_data;
  logic [WORD_W-1:0] mem_write_data;
  logic [WORD_W-1:0] mem_read_data = '0;
  logic cpu_read = 1'b0, cpu_write = 1'b0;
  logic dma_read = 1'b0, dma_write = 1'b0;
  logic cpu_read_ack, cpu_write_ack, cpu_nxm;
  logic dma_read_ack, dma_write_ack, dma_nxm;
  logic mem_read, mem_write;
  logic read_ack = 1'b0, write_ack = 1'b0;

  mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_write_data(cpu_write_data),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_read_data (cpu_read_data),
    .cpu_read_ack  (cpu_read_ack),
    .cpu_write_ack (cpu_write_ack),
    .cpu_nxm       (cpu_nxm),
    .dma_addr      (dma_addr),
    .dma_write_data(dma_write_data),
    .dma_read      (dma_read),
    .dma_write     (dma_write),
    .dma_read_data (dma_read_data),
    .dma_read_ack  (dma_read_ack),
    .dma_write_ack (dma_write_ack),
    .dma_nxm       (dma_nxm),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data),
    .read_ack      (read_ack),
    .write_ack     (write_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                dma;
    int                kind;
    logic [WORD_W-1:0] data;
    bit                chk_data;
    int                dly;
  } resp_t;

  typedef struct {
    bit                 wr;
    logic [PADDR_W-1:0] addr;
    logic [WORD_W-1:0]  data;
    int                 dly;
    bit                 dma;
  } mop_t;

  resp_t rq[$];
  mop_t  mq[$];
  resp_t rr;
  mop_t  mm;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int nstrobe = 0;
  int req_cyc[2];
  int mem_lat = 1;
  int cnt = 0;
  int n0 = 0;
  int kind = 0;
  bit pend_wr = 1'b0;
  bit mem_mute = 1'b0;
  bit inj_rd = 1'b0;
  bit noise = 1'b0;
  bit isd = 1'b0;
  logic [WORD_W-1:0]  rdata_next = '0;
  logic [PADDR_W-1:0] strobe_addr = '0;

  logic cpu_any, dma_any;
  assign cpu_any = cpu_read_ack | cpu_write_ack | cpu_nxm;
  assign dma_any = dma_read_ack | dma_write_ack | dma_nxm;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name,
        64'((|cpu_read_data) | (|dma_read_data) |
            (|mem_addr) | (|mem_write_data) |
            cpu_any | dma_any | mem_read | mem_write),
        64'd0);
  endtask

  task automatic push_m(input bit wr,
                        input logic [PADDR_W-1:0] a,
                        input logic [WORD_W-1:0] d,
                        input int dly, input bit dma);
    mop_t m;
    m = '{wr, a, d, dly, dma};
    mq.push_back(m);
  endtask

  task automatic push_r(input bit dma, input int k,
                        input logic [WORD_W-1:0] d,
                        input bit cd, input int dly);
    resp_t r;
    r = '{dma, k, d, cd, dly};
    rq.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called at #1 after a posedge; holds until ack/nxm
  task automatic do_req(input bit d, input bit rd,
                        input bit wr,
                        input logic [PADDR_W-1:0] a,
                        input logic [WORD_W-1:0] wd);
    bit seen = 1'b0;
    req_cyc[d] = cyc;
    if (d) begin
      dma_addr = a; dma_write_data = wd;
      dma_read = rd; dma_write = wr;
    end else begin
      cpu_addr = a; cpu_write_data = wd;
      cpu_read = rd; cpu_write = wr;
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (d ? dma_any : cpu_any) begin
        seen = 1'b1;
        break;
      end
    end
    chk(d ? "dma_req_done" : "cpu_req_done",
        64'(seen), 64'd1);
    if (d) begin
      dma_read = 1'b0; dma_write = 1'b0;
    end else begin
      cpu_read = 1'b0; cpu_write = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: acks mem_lat cycles after the strobe
  initial forever begin
    @(negedge clk);
    read_ack = 1'b0;
    write_ack = 1'b0;
    if (noise) begin
      read_ack = cyc[0];
      write_ack = ~cyc[0];
    end
    if (inj_rd) begin
      read_ack = 1'b1;
      inj_rd = 1'b0;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        chk("mem_addr_hold", 64'(mem_addr), 64'(strobe_addr));
        if (pend_wr) begin
          write_ack = 1'b1;
        end else begin
          read_ack = 1'b1;
          mem_read_data = rdata_next;
        end
      end
    end
    if (mem_read || mem_write) begin
      nstrobe++;
      strobe_cyc = cyc;
      strobe_addr = mem_addr;
      chk("mem_one_strobe", 64'(mem_read & mem_write), 64'd0);
      if (mq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected: got strobe at %0h want none",
                 mem_addr);
      end else begin
        mm = mq.pop_front();
        chk("mem_op", 64'(mem_write), 64'(mm.wr));
        chk("mem_addr", 64'(mem_addr), 64'(mm.addr));
        if (mm.wr)
          chk("mem_wdata", 64'(mem_write_data), 64'(mm.data));
        if (mm.dly >= 0)
          chk("strobe_latency",
              64'(cyc - req_cyc[mm.dma]), 64'(mm.dly));
      end
      pend_wr = mem_write;
      cnt = mem_mute ? 0 : mem_lat;
    end
  end

  // response monitor
  initial forever begin
    @(negedge clk);
    if (cpu_any || dma_any) begin
      chk("one_pulse",
          64'($countones({cpu_read_ack, cpu_write_ack, cpu_nxm,
                          dma_read_ack, dma_write_ack, dma_nxm})),
          64'd1);
      isd = dma_any;
      if (isd)
        kind = dma_write_ack ? 1 : (dma_nxm ? 2 : 0);
      else
        kind = cpu_write_ack ? 1 : (cpu_nxm ? 2 : 0);
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got who=%0d kind=%0d want none",
                 isd, kind);
      end else begin
        rr = rq.pop_front();
        chk("resp_who", 64'(isd), 64'(rr.dma));
        chk("resp_kind", 64'(kind), 64'(rr.kind));
        if (rr.chk_data)
          chk("resp_data",
              64'(isd ? dma_read_data : cpu_read_data),
              64'(rr.data));
        chk("resp_latency", 64'(cyc - strobe_cyc), 64'(rr.dly));
        if (isd)
          chk("cpu_quiet", 64'((|cpu_read_data) | cpu_any), 64'd0);
        else
          chk("dma_quiet", 64'((|dma_read_data) | dma_any), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with requests and ack noise
    reset = 1'b0;
    noise = 1'b1;
    cpu_write = 1'b1; cpu_addr = 18'o7;
    dma_write = 1'b1; dma_addr = 18'o12;
    repeat (2) begin
      @(posedge clk); #1;
      chk_zero("reset_quiet");
    end
    noise = 1'b0;
    @(posedge clk); #1;
    chk_zero("reset_quiet");
    push_m(1, 18'o7, 36'o1, 1, 0);
    push_m(1, 18'o12, 36'o2, -1, 1);
    push_r(0, 1, '0, 0, 2);
    push_r(1, 1, '0, 0, 2);
    reset = 1'b1;
    fork
      do_req(0, 0, 1, 18'o7, 36'o1);
      do_req(1, 0, 1, 18'o12, 36'o2);
    join

    // simultaneous writes alternate, CPU first twice
    for (int k = 0; k < 2; k++) begin
      idle(2);
      push_m(1, 18'o100 + 18'(k), 36'o111, 1, 0);
      push_m(1, 18'o200 + 18'(k), 36'o222, -1, 1);
      push_r(0, 1, '0, 0, 2);
      push_r(1, 1, '0, 0, 2);
      fork
        do_req(0, 0, 1, 18'o100 + 18'(k), 36'o111);
        do_req(1, 0, 1, 18'o200 + 18'(k), 36'o222);
      join
    end

    // single CPU read
    idle(2);
    rdata_next = 36'o123456701234;
    push_m(0, 18'o1000, '0, 1, 0);
    push_r(0, 0, 36'o123456701234, 1, 2);
    do_req(0, 1, 0, 18'o1000, '0);

    // last grant CPU: simultaneous reads, DMA first
    idle(2);
    rdata_next = 36'o777000777000;
    push_m(0, 18'o500, '0, 1, 1);
    push_m(0, 18'o400, '0, -1, 0);
    push_r(1, 0, 36'o777000777000, 1, 2);
    push_r(0, 0, 36'o777000777000, 1, 2);
    fork
      do_req(0, 1, 0, 18'o400, '0);
      do_req(1, 1, 0, 18'o500, '0);
    join

    // DMA read to absent memory -> NXM, late ack ignored
    idle(2);
    mem_mute = 1'b1;
    push_m(0, 18'o2345, '0, 1, 1);
    push_r(1, 2, '0, 1, 16);
    do_req(1, 1, 0, 18'o2345, '0);
    mem_mute = 1'b0;
    n0 = nstrobe;
    idle(2);
    inj_rd = 1'b1;
    idle(6);
    chk("late_ack_no_strobe", 64'(nstrobe), 64'(n0));

    // read+write together is a write
    push_m(1, 18'o5, 36'o55, 1, 0);
    push_r(0, 1, '0, 0, 2);
    do_req(0, 1, 1, 18'o5, 36'o55);

    // reset during WAIT of a DMA write
    idle(2);
    mem_mute = 1'b1;
    push_m(1, 18'o77, 36'o7, 1, 1);
    n0 = nstrobe;
    req_cyc[1] = cyc;
    dma_addr = 18'o77; dma_write_data = 36'o7;
    dma_write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (nstrobe != n0) break;
    end
    chk("abort_strobe_seen", 64'(nstrobe), 64'(n0 + 1));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_zero("abort_zero");
    reset = 1'b1;
    dma_write = 1'b0;
    mem_mute = 1'b0;
    idle(3);
    rdata_next = 36'o42;
    push_m(0, 18'o3000, '0, 1, 0);
    push_r(0, 0, 36'o42, 1, 2);
    do_req(0, 1, 0, 18'o3000, '0);

    idle(3);
    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("mem_queue_empty", 64'(mq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
